cpu_clk_stepper: RTL and testbench
==================================

// Module: cpu_clk_stepper
// PURPOSE
//  Run/single-step CPU clock controller, upstream of the CPU clock divider.
//  Syncs and debounces the board run switch and step button on sysclk, then
//  produces a divided CPU clock that runs freely, issues exactly one period
//  per step press, or stays parked low. Gives the CPU clean, glitch-free
//  edges for board debug.
// PARAMETERS
//  DIV_HALF         5   sysclk cycles per cpu_clk half-period (>=1)
//  DEBOUNCE_CYCLES  16  consecutive stable sysclk cycles to accept an input (>=2)
//  CNT_W            16  width of cycle_count
// PORTS
//  sysclk        in   1      system clock; all logic on its posedge
//  reset         in   1      asynchronous, active-low reset
//  run_sw        in   1      raw run switch, 1 = free-run (async to sysclk)
//  step_btn      in   1      raw step pushbutton, 1 = pressed (async)
//  cpu_clk       out  1      registered CPU clock
//  cpu_clk_rise  out  1      1-sysclk pulse in the cycle cpu_clk goes 0->1
//  halted        out  1      1 while FSM is IDLE (cpu_clk parked low)
//  cycle_count   out  CNT_W  number of cpu_clk rising edges since reset
// BEHAVIOUR
//  Reset (async, reset=0): every flop cleared at once; cpu_clk=0,
//   cpu_clk_rise=0, halted=1, cycle_count=0, FSM=IDLE. Reset release resumes
//   from IDLE; a reset mid-period truncates the period with no extra edge.
//  Sync: run_sw, step_btn each pass a 2-flop synchronizer (reset value 0).
//  Debounce (per input): counter counts cycles where synced != debounced;
//   cleared whenever they agree. When it reaches DEBOUNCE_CYCLES-1 and they
//   still differ, debounced <= synced and counter <= 0. Debounced value
//   changes DEBOUNCE_CYCLES cycles after the synced value settles.
//   step_req = 1-cycle pulse on debounced step_btn 0->1.
//  Divider: div_cnt runs 0..DIV_HALF-1 only in RUN/STEP; forced to 0 in IDLE.
//   tick = (div_cnt==DIV_HALF-1); each tick toggles cpu_clk.
//  FSM:
//   IDLE: run_db=1 -> RUN; else step_req -> STEP; else stay. run_db wins.
//   RUN : toggle on tick. If run_db=0 at a tick that drives cpu_clk 1->0
//         -> IDLE (a started period always completes; cpu_clk never left high).
//   STEP: first tick cpu_clk 0->1, second tick 1->0 and -> IDLE.
//  First cpu_clk rise is DIV_HALF sysclk cycles after leaving IDLE; period
//   is 2*DIV_HALF. step_req in RUN or STEP is dropped, not queued. run_db
//   rising during STEP: STEP completes, IDLE one cycle, then RUN.
//  cpu_clk_rise asserted on the same edge cpu_clk becomes 1, else 0.
//  halted = (state==IDLE), registered alongside state.
//  cycle_count increments on every cpu_clk 0->1; wraps 2^CNT_W-1 -> 0.
// CONFIGURATION
//  STEPPER_CYCLE_COUNT_EN defined: cycle_count counter implemented as above.
//  Not defined: no counter flops; cycle_count tied to all zeros; all other
//   behaviour unchanged.
// TESTING (bench params: DIV_HALF=2, DEBOUNCE_CYCLES=4, CNT_W=8, macro on)
//  Reset: hold reset=0 with run_sw=1 -> cpu_clk=0, halted=1, cycle_count=0
//   throughout; reset mid-RUN with cpu_clk=1 -> cpu_clk=0 immediately.
//  Free-run: run_sw=1 -> halted=0 after 2+4+1 cycles; cpu_clk period 4
//   sysclk, 50% duty; after 10 rises cycle_count=10, each with 1-cycle rise pulse.
//  Stop: drop run_sw while cpu_clk=1 -> one more falling edge, then halted=1,
//   cpu_clk stays 0, no further rises.
//  Step: one clean press -> exactly one cpu_clk pulse (2 sysclk high),
//   cycle_count +1, halted=1 afterwards; second press in STEP ignored.
//  Bounce: step_btn toggling every 2 sysclk for 20 cycles then low -> zero
//   cpu_clk pulses; bounce then stable-high 4+ cycles -> exactly one pulse.
//  Wrap: 256 rises from 0 -> cycle_count=0; with macro undefined stays 0.

Source files
------------

// File: rtl/cpu_clk_stepper.sv
// Run/single-step CPU clock controller: synchronizes and debounces run/step inputs, emits a divided cpu_clk.
// Optional cycle counter enabled by defining STEPPER_CYCLE_COUNT_EN (otherwise cycle_count is tied to zero).
module cpu_clk_stepper #(
  parameter int DIV_HALF        = 5,
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int CNT_W           = 16
) (
  input  logic             sysclk,
  input  logic             reset,
  input  logic             run_sw,
  input  logic             step_btn,
  output logic             cpu_clk,
  output logic             cpu_clk_rise,
  output logic             halted,
  output logic [CNT_W-1:0] cycle_count
);

  localparam int DIV_W = (DIV_HALF > 1) ? $clog2(DIV_HALF) : 1;
  localparam int DB_W  = $clog2(DEBOUNCE_CYCLES);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV_HALF - 1);
  localparam logic [DB_W-1:0]  DB_LAST  = DB_W'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    STEP = 2'd2
  } state_t;

  // bit 0 = run switch, bit 1 = step button
  logic [1:0]            raw_s;
  logic [1:0]            meta_r;
  logic [1:0]            sync_r;
  logic [1:0]            db_r;
  logic [1:0][DB_W-1:0]  dbc_r;
  logic                  step_db_d_r;
  logic                  run_db_s;
  logic                  step_req_s;

  state_t                state_r;
  state_t                state_nxt_s;
  logic [DIV_W-1:0]      div_cnt_r;
  logic [DIV_W-1:0]      div_nxt_s;
  logic                  tick_s;
  logic                  clk_nxt_s;
  logic                  rise_s;

  assign raw_s      = {step_btn, run_sw};
  assign run_db_s   = db_r[0];
  assign step_req_s = db_r[1] & ~step_db_d_r;
  assign rise_s     = tick_s & ~cpu_clk;

  // Two-flop synchronizers for both raw inputs
  always_ff @(posedge sysclk or negedge reset) begin
    if (!reset) begin
      meta_r <= 2'b00;
      sync_r <= 2'b00;
    end else begin
      meta_r <= raw_s;
      sync_r <= meta_r;
    end
  end

  // Debounce: accept a new level only after it has disagreed for DEBOUNCE_CYCLES cycles
  always_ff @(posedge sysclk or negedge reset) begin
    if (!reset) begin
      db_r        <= 2'b00;
      dbc_r       <= '0;
      step_db_d_r <= 1'b0;
    end else begin
      step_db_d_r <= db_r[1];
      for (int i = 0; i < 2; i++) begin
        if (sync_r[i] == db_r[i]) begin
          dbc_r[i] <= '0;
        end else if (dbc_r[i] == DB_LAST) begin
          db_r[i]  <= sync_r[i];
          dbc_r[i] <= '0;
        end else begin
          dbc_r[i] <= dbc_r[i] + DB_W'(1);
        end
      end
    end
  end

  // Next-state, divider and clock-level logic
  always_comb begin
    state_nxt_s = state_r;
    clk_nxt_s   = cpu_clk;
    div_nxt_s   = '0;
    tick_s      = (state_r != IDLE) && (div_cnt_r == DIV_LAST);
    case (state_r)
      IDLE: begin
        clk_nxt_s = 1'b0;
        if (run_db_s) begin
          state_nxt_s = RUN;
        end else if (step_req_s) begin
          state_nxt_s = STEP;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      RUN: begin
        if (tick_s) begin
          clk_nxt_s = ~cpu_clk;
          // only stop on a falling edge so a started period always completes
          if (cpu_clk && !run_db_s) begin
            state_nxt_s = IDLE;
          end else begin
            state_nxt_s = RUN;
          end
        end else begin
          div_nxt_s = div_cnt_r + DIV_W'(1);
        end
      end
      STEP: begin
        if (tick_s) begin
          clk_nxt_s = ~cpu_clk;
          if (cpu_clk) begin
            state_nxt_s = IDLE;
          end else begin
            state_nxt_s = STEP;
          end
        end else begin
          div_nxt_s = div_cnt_r + DIV_W'(1);
        end
      end
      default: begin
        state_nxt_s = IDLE;
        clk_nxt_s   = 1'b0;
      end
    endcase
  end

  // State, divider and registered clock outputs
  always_ff @(posedge sysclk or negedge reset) begin
    if (!reset) begin
      state_r      <= IDLE;
      div_cnt_r    <= '0;
      cpu_clk      <= 1'b0;
      cpu_clk_rise <= 1'b0;
      halted       <= 1'b1;
    end else begin
      state_r      <= state_nxt_s;
      div_cnt_r    <= div_nxt_s;
      cpu_clk      <= clk_nxt_s;
      cpu_clk_rise <= rise_s;
      halted       <= (state_nxt_s == IDLE);
    end
  end

`ifdef STEPPER_CYCLE_COUNT_EN
  logic [CNT_W-1:0] count_r;

  // Rising-edge counter, wraps naturally
  always_ff @(posedge sysclk or negedge reset) begin
    if (!reset) begin
      count_r <= '0;
    end else if (rise_s) begin
      count_r <= count_r + CNT_W'(1);
    end else begin
      count_r <= count_r;
    end
  end

  assign cycle_count = count_r;
`else
  assign cycle_count = '0;
`endif

endmodule

// File: tb/tb_cpu_clk_stepper.sv
// Self-checking bench for cpu_clk_stepper: directed scenarios plus random input activity vs. a timing model.
module tb_cpu_clk_stepper;

  localparam int DH = 2;
  localparam int DB = 4;
  localparam int CW = 8;
`ifdef STEPPER_CYCLE_COUNT_EN
  localparam bit CNT_ON = 1'b1;
`else
  localparam bit CNT_ON = 1'b0;
`endif

  logic          sysclk = 1'b0;
  logic          reset = 1'b1;
  logic          run_sw = 1'b0;
  logic          step_btn = 1'b0;
  logic          cpu_clk;
  logic          cpu_clk_rise;
  logic          halted;
  logic [CW-1:0] cycle_count;

  int total = 0;
  int bad = 0;

  // model state: input pipelines as history windows, clock as a phase count since leaving idle
  logic          m_rmeta, m_rsync, m_rdb;
  logic          m_smeta, m_ssync, m_sdb, m_sdb_d;
  logic [DB-2:0] m_rhist, m_shist;
  int            m_mode;   // 0 idle, 1 run, 2 step
  int            m_p;
  logic          m_clk, m_rise, m_halt;
  int            m_rises;

  cpu_clk_stepper #(.DIV_HALF(DH), .DEBOUNCE_CYCLES(DB), .CNT_W(CW)) dut (
    .sysclk(sysclk), .reset(reset), .run_sw(run_sw), .step_btn(step_btn),
    .cpu_clk(cpu_clk), .cpu_clk_rise(cpu_clk_rise), .halted(halted),
    .cycle_count(cycle_count)
  );

  always #5 sysclk = ~sysclk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h t=%0t", tag, obs, exp, $time);
    end
  endtask

  task automatic m_reset();
    m_rmeta = 1'b0; m_rsync = 1'b0; m_rdb = 1'b0; m_rhist = '0;
    m_smeta = 1'b0; m_ssync = 1'b0; m_sdb = 1'b0; m_sdb_d = 1'b0; m_shist = '0;
    m_mode = 0; m_p = 0; m_clk = 1'b0; m_rise = 1'b0; m_halt = 1'b1; m_rises = 0;
  endtask

  function automatic logic [31:0] exp_count(input int rises);
    return CNT_ON ? 32'(rises % (1 << CW)) : 32'd0;
  endfunction

  task automatic m_edge();
    logic [DB-1:0] rwin, swin;
    logic run_db_old, step_req;
    int q;
    if (!reset) begin
      m_reset();
      return;
    end
    run_db_old = m_rdb;
    step_req   = m_sdb & ~m_sdb_d;
    rwin = {m_rhist, m_rsync};
    swin = {m_shist, m_ssync};
    m_sdb_d = m_sdb;
    // a debounced level flips once the last DB synced samples all disagree with it
    if (rwin == {DB{~m_rdb}}) m_rdb = ~m_rdb;
    if (swin == {DB{~m_sdb}}) m_sdb = ~m_sdb;
    m_rhist = rwin[DB-2:0]; m_rsync = m_rmeta; m_rmeta = run_sw;
    m_shist = swin[DB-2:0]; m_ssync = m_smeta; m_smeta = step_btn;
    m_rise = 1'b0;
    if (m_mode == 0) begin
      m_clk = 1'b0;
      if (run_db_old) begin
        m_mode = 1; m_p = 0;
      end else if (step_req) begin
        m_mode = 2; m_p = 0;
      end
    end else begin
      q = m_p + 1;
      m_p = q;
      m_clk = ((q / DH) % 2) == 1;
      if (q % (2 * DH) == DH) begin
        m_rise = 1'b1;
        m_rises++;
      end
      if (q % (2 * DH) == 0 && (m_mode == 2 || !run_db_old)) m_mode = 0;
    end
    m_halt = (m_mode == 0);
  endtask

  task automatic cmp_all(input string tag);
    check({tag, ".cpu_clk"}, 32'(cpu_clk), 32'(m_clk));
    check({tag, ".rise"}, 32'(cpu_clk_rise), 32'(m_rise));
    check({tag, ".halted"}, 32'(halted), 32'(m_halt));
    check({tag, ".count"}, 32'(cycle_count), exp_count(m_rises));
  endtask

  task automatic cyc(input string tag);
    m_edge();
    @(posedge sysclk);
    #1;
    cmp_all(tag);
  endtask

  task automatic async_reset();
    #2 reset = 1'b0;
    #1;
    m_reset();
    check("async_rst.cpu_clk", 32'(cpu_clk), 32'd0);
    check("async_rst.halted", 32'(halted), 32'd1);
    check("async_rst.rise", 32'(cpu_clk_rise), 32'd0);
    check("async_rst.count", 32'(cycle_count), 32'd0);
  endtask

  initial begin
    int r0;
    m_reset();
    #1 reset = 1'b0;
    run_sw = 1'b1;
    for (int i = 0; i < 8; i++) cyc("rst_hold");

    // free-run from reset release
    reset = 1'b1;
    for (int i = 0; i < 6; i++) cyc("start");
    check("start.halted_6", 32'(halted), 32'd1);
    cyc("start");
    check("start.halted_7", 32'(halted), 32'd0);
    for (int i = 0; i < 200 && m_rises < 10; i++) cyc("run");
    check("run.count10", 32'(cycle_count), exp_count(10));
    for (int i = 0; i < 5; i++) cyc("run");

    // stop while cpu_clk high
    for (int i = 0; i < 10 && !m_clk; i++) cyc("pre_stop");
    run_sw = 1'b0;
    for (int i = 0; i < 30; i++) cyc("stop");
    check("stop.halted", 32'(halted), 32'd1);
    r0 = m_rises;

    // one clean step press
    step_btn = 1'b1;
    for (int i = 0; i < 12; i++) cyc("step");
    step_btn = 1'b0;
    for (int i = 0; i < 20; i++) cyc("step");
    check("step.count_plus1", 32'(cycle_count), exp_count(r0 + 1));
    check("step.halted", 32'(halted), 32'd1);

    // bounce only: no pulse
    r0 = m_rises;
    for (int i = 0; i < 20; i++) begin
      if (i % 2 == 0) step_btn = ~step_btn;
      cyc("bounce");
    end
    step_btn = 1'b0;
    for (int i = 0; i < 20; i++) cyc("bounce");
    check("bounce.no_pulse", 32'(cycle_count), exp_count(r0));

    // bounce then stable high: exactly one pulse
    for (int i = 0; i < 10; i++) begin
      if (i % 2 == 0) step_btn = ~step_btn;
      cyc("bounce_hi");
    end
    step_btn = 1'b1;
    for (int i = 0; i < 10; i++) cyc("bounce_hi");
    step_btn = 1'b0;
    for (int i = 0; i < 20; i++) cyc("bounce_hi");
    check("bounce_hi.one_pulse", 32'(cycle_count), exp_count(r0 + 1));

    // step press during RUN is dropped
    run_sw = 1'b1;
    for (int i = 0; i < 12; i++) cyc("run_step");
    step_btn = 1'b1;
    for (int i = 0; i < 10; i++) cyc("run_step");
    run_sw = 1'b0;
    step_btn = 1'b0;
    for (int i = 0; i < 30; i++) cyc("run_step");

    // reset mid-RUN with cpu_clk high
    run_sw = 1'b1;
    for (int i = 0; i < 100 && !m_clk; i++) cyc("pre_rst");
    check("pre_rst.clk_high", 32'(cpu_clk), 32'd1);
    async_reset();
    for (int i = 0; i < 3; i++) cyc("rst_low");
    reset = 1'b1;

    // wrap of the rise counter
    for (int i = 0; i < 2000 && m_rises < 255; i++) cyc("wrap");
    check("wrap.255", 32'(cycle_count), exp_count(255));
    for (int i = 0; i < 10 && m_rises < 256; i++) cyc("wrap");
    check("wrap.zero", 32'(cycle_count), 32'd0);
    run_sw = 1'b0;

    // random activity on both inputs
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 99) < 2) run_sw = ~run_sw;
      if ($urandom_range(0, 99) < 15) step_btn = ~step_btn;
      cyc("rand");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
